// File: rtl/move_history_stack.sv
// move_history_stack: LIFO ring-buffer move log that replays popped records to the board updater with undo set.
// Ports: clk/clear (sync active-high); push + in_* capture a record; undo_req pops the top record;
// out_valid/out_ready handshake the replayed fields; count/empty/full report occupancy;
// dropped pulses when the oldest record is overwritten, rej pulses when a request is refused.
module move_history_stack #(
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          push,
  input  logic          in_color_type,
  input  logic [63:0]   in_initialPosition,
  input  logic [63:0]   in_movedPosition,
  input  logic [5:0]    in_movingPiece,
  input  logic [5:0]    in_capturedPiece,
  input  logic [1:0]    in_castling,
  input  logic [4:0]    in_enpassant,
  input  logic          undo_req,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          color_type,
  output logic [63:0]   initialPosition,
  output logic [63:0]   movedPosition,
  output logic [5:0]    movingPiece,
  output logic [5:0]    capturedPiece,
  output logic [1:0]    castling,
  output logic [4:0]    enpassant,
  output logic          undo,
  output logic [PW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          dropped,
  output logic          rej
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;
  localparam logic [PW:0] fullCount = (PW+1)'(DEPTH);
  logic [1:0] state;
  logic [PW-1:0] top;
  logic [PW-1:0] rdAddr;
  logic [147:0] mem [DEPTH];
  logic [147:0] rec;
  logic [147:0] inRec;
  logic doPush;
  assign inRec = {in_color_type, in_initialPosition, in_movedPosition, in_movingPiece,
                  in_capturedPiece, in_castling, in_enpassant};
  assign {color_type, initialPosition, movedPosition, movingPiece, capturedPiece, castling, enpassant} = rec;
  assign doPush = push && state == IDLE;
  assign out_valid = state == PRESENT;
  assign undo = out_valid;
  assign empty = count == '0;
  assign full = count == fullCount;
  always_ff @(posedge clk)
    if (!clear && doPush) mem[top] <= inRec;
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      top <= '0;
      count <= '0;
      rdAddr <= '0;
      rec <= '0;
      dropped <= 1'b0;
      rej <= 1'b0;
    end else begin
      dropped <= 1'b0;
      rej <= 1'b0;
      if (state == IDLE) begin
        if (push) begin
          top <= top + PW'(1);
          count <= full ? count : count + (PW+1)'(1);
          dropped <= full;
          rej <= undo_req;
        end else if (undo_req) begin
          rej <= empty;
          rdAddr <= top - PW'(1);
          state <= empty ? IDLE : READ;
        end
      end else begin
        rej <= push || undo_req;
        if (state == READ) begin
          rec <= mem[rdAddr];
          state <= PRESENT;
        end else if (out_ready) begin
          top <= top - PW'(1);
          count <= count - (PW+1)'(1);
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: doc/move_history_stack.md
# move_history_stack

LIFO move log that sits upstream of the board updater and drives its move-record inputs in the reverse direction. Each committed move is pushed as a full move record; on an undo request the most recent record is popped and replayed to the board updater with `undo` asserted, so the updater reverses that move. The log is a ring buffer. When it is full, a new push overwrites the oldest entry, so an unbounded game always keeps its last DEPTH moves undoable.

## Interface
- DEPTH, 16, number of stored moves; power of two, ≥2
- PW, log2(DEPTH), pointer width (derived, not overridable)

- clk  in  1  rising-edge clock
- clear  in  1  synchronous active-high reset
- push  in  1  1-cycle strobe: capture in_* as a new record
- in_color_type  in  1  1 white, 0 black
- in_initialPosition  in  64  one-hot source square
- in_movedPosition  in  64  one-hot destination square
- in_movingPiece  in  6  one-hot: 000001 pawn, 000010 rook, 000100 knight, 001000 bishop, 010000 queen, 100000 king
- in_capturedPiece  in  6  same encoding; 000000 = none
- in_castling  in  2  00 none, 01 queen side, 10 king side
- in_enpassant  in  5  00001 none, 00010 UL, 00100 UR, 01000 DL, 10000 DR
- undo_req  in  1  1-cycle strobe: pop and replay top record
- out_ready  in  1  updater accepts the presented record
- out_valid  out  1  record presented
- color_type, initialPosition, movedPosition, movingPiece, capturedPiece, castling, enpassant  out  as in_*  popped record fields
- undo  out  1  equals out_valid
- count  out  PW+1  stored records, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- dropped  out  1  1-cycle pulse: the oldest record was overwritten
- rej  out  1  1-cycle pulse: a request was rejected

## Operation
- Storage: DEPTH × 148-bit records. Fields are stored as given, with no validation.
- Pointers: `top` (PW bits) is the next write slot and wraps modulo DEPTH. The slot to pop is `top-1` mod DEPTH.
- FSM states:
  - IDLE
    - push: write slot `top`, `top+1`.
      - If count<DEPTH: count+1.
      - Else: count stays DEPTH and `dropped` pulses.
    - undo_req with count>0: latch address `top-1`, go to READ.
    - undo_req with count==0: `rej` pulses, stay in IDLE.
    - push and undo_req in the same cycle: the push executes, the undo_req is dropped, and `rej` pulses.
  - READ: the memory read completes in one cycle; load the output fields; go to PRESENT.
  - PRESENT
    - out_valid=1.
    - On out_valid&&out_ready: `top-1`, count-1, go to IDLE.
- push in READ or PRESENT is ignored and `rej` pulses. undo_req in READ or PRESENT is ignored and `rej` pulses.
- Output fields:
  - Hold their values from the READ load until the next READ load.
  - Stable while out_valid && !out_ready.
- undo is a combinational copy of out_valid.
- clear has priority over all other inputs. At the next edge:
  - FSM to IDLE.
  - top=0, count=0.
  - out_valid, dropped and rej all 0.
  - All output fields 0.
  - Memory contents are not cleared; they are unreachable because count=0.
- Reset values: out_valid=0, undo=0, all record outputs 0, count=0, empty=1, full=0, dropped=0, rej=0.

## Timing
- push sampled at edge N → count/full/empty updated after edge N. A record pushed at edge N can be requested from cycle N+1.
- undo_req sampled at edge N (IDLE, count>0) → READ after N, out_valid=1 after N+1. Latency is 2 cycles to the first valid.
- out_ready high at edge M while out_valid=1 → out_valid=0, count-1 after M. A new undo_req is accepted from edge M+1.
- out_ready is ignored when out_valid=0.
- With out_ready tied high, one pop occupies 3 cycles (IDLE→READ→PRESENT→IDLE). Back-to-back undo_req pulses every 3 cycles are all served.
- dropped and rej are single-cycle pulses, registered and asserted in the cycle after the causing edge.
- clear during PRESENT: out_valid falls after the clear edge even if out_ready is low. The in-flight record is not popped to the updater but count becomes 0.

## Test plan
- Reset: hold clear 2 cycles → count=0, empty=1, full=0, out_valid=0, undo=0, all record outputs 0.
- Single round trip: push {white, init=1<<12, moved=1<<28, pawn, none, 00, 00001}, then undo_req with out_ready=1 → out_valid and undo high exactly 2 cycles after undo_req, fields match the pushed record, count goes 1→0, empty=1.
- LIFO order: push A (1<<49→1<<56, pawn, captured rook), then B (1<<4→1<<6, king, castling 10), then pop twice → B then A, with B.castling=10 and A.capturedPiece=000010.
- Overflow/wrap: DEPTH=16, push 17 records tagged movedPosition=1<<k, k=0..16 → dropped pulses once on the 17th push, count=16, full=1. Sixteen pops return k=16 down to k=1, and a further undo_req gives rej=1 with no out_valid.
- Backpressure and busy: hold out_ready=0 for 5 cycles in PRESENT while pulsing push and undo_req → outputs stable, out_valid held, rej pulses for each request, count unchanged. Release out_ready → count-1.
- Clear mid-operation: 3 records, undo_req, assert clear in the PRESENT cycle with out_ready=0 → out_valid=0 and count=0 next cycle. A subsequent undo_req gives rej=1.
